// File: rtl/int_to_float_seq.sv
// int_to_float_seq: iterative 32-bit signed integer to IEEE-754 single.
// Define I2F_ROUND_NEAREST_EN for round-to-nearest-even, else truncate.
module int_to_float_seq #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_OUT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_alive;
    logic        r_sign;
    logic        r_zero;
    logic [31:0] r_mag;
    logic [8:0]  r_exp;
    logic [31:0] r_out;

    logic            w_take;
    logic [31:0]     w_abs;
    logic [STEP-1:0] w_top;
    logic [22:0]     w_mant;
    logic            w_inc;
    logic [23:0]     w_sum;
    logic [8:0]      w_rexp;
    logic [31:0]     w_res;
    logic            w_unused_msb;

    assign in_ready  = (r_state == S_IDLE) && r_alive;
    assign out_valid = (r_state == S_OUT);
    assign busy      = (r_state != S_IDLE);
    assign out_data  = r_out;

    assign w_take = in_valid && in_ready;
    assign w_abs  = in_data[31] ? (~in_data + 32'd1) : in_data;
    assign w_top  = r_mag[31-:STEP];
    assign w_mant = r_mag[30:8];

`ifdef I2F_ROUND_NEAREST_EN
    logic w_guard;
    logic w_sticky;
    assign w_guard  = r_mag[7];
    assign w_sticky = |r_mag[6:0];
    assign w_inc    = w_guard && (w_sticky || w_mant[0]);
`else
    assign w_inc = 1'b0;
`endif

    // A carry out of the mantissa renormalises to 1.0 x 2^(exp+1).
    assign w_sum        = {1'b0, w_mant} + {23'd0, w_inc};
    assign w_rexp       = r_exp + {8'd0, w_sum[23]};
    assign w_unused_msb = w_rexp[8];
    assign w_res        = r_zero ? 32'd0
                        : {r_sign, w_rexp[7:0], w_sum[22:0]};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                // Zero skips normalisation but keeps a one-cycle latency.
                if (w_take) begin
                    w_next = (in_data == 32'd0) ? S_ROUND : S_NORM;
                end
            end
            S_NORM: begin
                if (r_mag[31]) begin
                    w_next = S_ROUND;
                end
            end
            S_ROUND: begin
                w_next = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_alive <= 1'b0;
            r_sign  <= 1'b0;
            r_zero  <= 1'b0;
            r_mag   <= 32'd0;
            r_exp   <= 9'd0;
            r_out   <= 32'd0;
        end else begin
            r_state <= w_next;
            r_alive <= 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_sign <= in_data[31];
                        r_zero <= (in_data == 32'd0);
                        r_mag  <= w_abs;
                        r_exp  <= 9'd158;
                    end
                end
                S_NORM: begin
                    if (!r_mag[31]) begin
                        if (w_top == '0) begin
                            r_mag <= r_mag << STEP;
                            r_exp <= r_exp - 9'(STEP);
                        end else begin
                            r_mag <= r_mag << 1;
                            r_exp <= r_exp - 9'd1;
                        end
                    end
                end
                S_ROUND: begin
                    r_out <= w_res;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_float_seq.sv
// Directed self-checking bench for int_to_float_seq (STEP=1).
// Expected floats and latencies are hand-computed per build.
module tb_int_to_float_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int n_cmp;
    int n_err;

    int_to_float_seq #(.STEP(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents d, waits for the result; leaves out_valid pending.
    task automatic start_conv(input logic [31:0] d,
                              output int lat,
                              output bit to);
        int w;
        to = 1'b0;
        lat = 0;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        if (!in_ready) begin
            to = 1'b1;
        end else begin
            in_valid = 1'b1;
            in_data  = d;
            tick();
            in_valid = 1'b0;
            while (!out_valid && lat < 100) begin
                tick();
                lat++;
            end
            if (!out_valid) to = 1'b1;
        end
    endtask

    task automatic finish_conv();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_in_ready got=%b exp=0", in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_out_valid got=%b exp=0", out_valid);
        end
        n_cmp++;
        if (out_data !== 32'd0) begin
            n_err++;
            $display("FAIL rst_out_data got=%h exp=0", out_data);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_busy got=%b exp=0", busy);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rel_in_ready got=%b exp=0", in_ready);
        end
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rise_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_convert();
        logic [31:0] vin [10];
        logic [31:0] vexp[10];
        int          vlat[10];
        int          lat;
        bit          to;
        vin[0] = 32'h0000_0001; vexp[0] = 32'h3F80_0000; vlat[0] = 33;
        vin[1] = 32'hFFFF_FFFF; vexp[1] = 32'hBF80_0000; vlat[1] = 33;
        vin[2] = 32'h0000_0000; vexp[2] = 32'h0000_0000; vlat[2] = 1;
        vin[3] = 32'h8000_0000; vexp[3] = 32'hCF00_0000; vlat[3] = 2;
        vin[4] = 32'h0000_0005; vexp[4] = 32'h40A0_0000; vlat[4] = 31;
        vin[5] = 32'hFFFF_FF9C; vexp[5] = 32'hC2C8_0000; vlat[5] = 27;
        vin[6] = 32'h0100_0001; vexp[6] = 32'h4B80_0000; vlat[6] = 9;
`ifdef I2F_ROUND_NEAREST_EN
        vin[7] = 32'h7FFF_FFFF; vexp[7] = 32'h4F00_0000; vlat[7] = 3;
        vin[8] = 32'h0100_0003; vexp[8] = 32'h4B80_0002; vlat[8] = 9;
        vin[9] = 32'h8000_0001; vexp[9] = 32'hCF00_0000; vlat[9] = 3;
`else
        vin[7] = 32'h7FFF_FFFF; vexp[7] = 32'h4EFF_FFFF; vlat[7] = 3;
        vin[8] = 32'h0100_0003; vexp[8] = 32'h4B80_0001; vlat[8] = 9;
        vin[9] = 32'h8000_0001; vexp[9] = 32'hCEFF_FFFF; vlat[9] = 3;
`endif
        for (int i = 0; i < 10; i++) begin
            start_conv(vin[i], lat, to);
            n_cmp++;
            if (to) begin
                n_err++;
                $display("FAIL conv_timeout in=%h", vin[i]);
            end else begin
                if (out_data !== vexp[i]) begin
                    n_err++;
                    $display("FAIL conv_data in=%h got=%h exp=%h",
                             vin[i], out_data, vexp[i]);
                end
                n_cmp++;
                if (lat != vlat[i]) begin
                    n_err++;
                    $display("FAIL conv_lat in=%h got=%0d exp=%0d",
                             vin[i], lat, vlat[i]);
                end
                finish_conv();
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        start_conv(32'd5, lat, to);
        n_cmp++;
        if (to) begin
            n_err++;
            $display("FAIL bp_timeout");
        end else begin
            for (int c = 0; c < 5; c++) begin
                in_valid = c[0];
                in_data  = 32'h0000_1000 + 32'(c);
                tick();
                n_cmp++;
                if (out_data !== 32'h40A0_0000 || out_valid !== 1'b1 ||
                    in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL bp_hold c=%0d got=%h/%b/%b exp=40a00000/1/0",
                             c, out_data, out_valid, in_ready);
                end
            end
            in_valid  = 1'b1;
            in_data   = 32'h0001_2345;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            in_valid  = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL bp_release got=%b/%b exp=0/0",
                         out_valid, busy);
            end
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL bp_ready got=%b exp=1", in_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        int  lat;
        bit  to;
        bit  seen;
        in_valid = 1'b1;
        in_data  = 32'd1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_busy got=%b exp=1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_rst got=%b/%b/%b exp=0/0/0",
                     out_valid, busy, in_ready);
        end
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL mid_ghost got=1 exp=0");
        end
        start_conv(32'hFFFF_FFFF, lat, to);
        n_cmp++;
        if (to || out_data !== 32'hBF80_0000) begin
            n_err++;
            $display("FAIL mid_after got=%h to=%b exp=bf800000",
                     out_data, to);
        end
        if (!to) finish_conv();
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        test_reset();
        test_convert();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
